// File: rtl/ic74x153_scan_reader.sv
// Scan sequencer for a 74x153 dual 4-to-1 mux. Walks the four addresses, samples both
// mux outputs after SETTLE cycles at each address, and publishes two 4-bit words.
module ic74x153_scan_reader #(
    parameter int SETTLE       = 1,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_sel_hi,
    output logic       o_sel_lo,
    output logic       o_g1,
    output logic       o_g2,
    input  logic       i_y1,
    input  logic       i_y2,
    output logic [3:0] o_q1,
    output logic [3:0] o_q2,
    output logic       o_valid,
    output logic       o_busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;
    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);

    if (SETTLE < 1) begin : g_bad_settle
        $error("ic74x153_scan_reader: SETTLE must be at least 1");
    end

    logic [0:0] r_state;
    logic [1:0] r_addr;
    logic [3:0] r_cnt;
    logic [3:0] r_s1;
    logic [3:0] r_s2;
    logic [3:0] r_q1;
    logic [3:0] r_q2;
    logic       r_valid;
    logic       w_scanning;

    assign w_scanning = (r_state == ST_SCAN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_addr  <= 2'd0;
            r_cnt   <= 4'd0;
            r_s1    <= 4'd0;
            r_s2    <= 4'd0;
            r_q1    <= 4'd0;
            r_q2    <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_SCAN;
                        r_addr  <= 2'd0;
                        r_cnt   <= CNT_RELOAD;
                    end
                end
                ST_SCAN: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_s1[r_addr] <= i_y1;
                        r_s2[r_addr] <= i_y2;
                        if (r_addr != 2'd3) begin
                            r_addr <= r_addr + 2'd1;
                            r_cnt  <= CNT_RELOAD;
                        end else begin
                            // The last sample bypasses the shadow so q is complete on this edge.
                            r_q1    <= {i_y1, r_s1[2:0]};
                            r_q2    <= {i_y2, r_s2[2:0]};
                            r_valid <= 1'b1;
                            r_addr  <= 2'd0;
                            if (AUTO_RESTART) begin
                                r_cnt <= CNT_RELOAD;
                            end else begin
                                r_state <= ST_IDLE;
                                r_cnt   <= 4'd0;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Select pins come straight from the address flops so the mux never sees a decode glitch.
    assign o_sel_hi = r_addr[1];
    assign o_sel_lo = r_addr[0];
    assign o_g1     = ~w_scanning;
    assign o_g2     = ~w_scanning;
    assign o_busy   = w_scanning;
    assign o_q1     = r_q1;
    assign o_q2     = r_q2;
    assign o_valid  = r_valid;

endmodule

// File: tb/tb_ic74x153_scan_reader.sv
// Bench for ic74x153_scan_reader: three instances (SETTLE 1/3/2, last one auto-restarting),
// each wired to a behavioural '153, checked against a timeline model through a scoreboard.
module tb_ic74x153_scan_reader;

    localparam int N = 3;
    localparam int SET [N] = '{1, 3, 2};
    localparam bit AR  [N] = '{1'b0, 1'b0, 1'b1};

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  q1;
        logic [3:0]  q2;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] start = '0;
    logic [N-1:0] sel_hi, sel_lo, g1, g2, y1, y2, valid, busy;
    logic [3:0] q1 [N];
    logic [3:0] q2 [N];
    // p1[k][i] / p2[k][i] are the '153 data pins selected by address i
    logic [3:0] p1 [N];
    logic [3:0] p2 [N];

    int vectors = 0;
    int miscompares = 0;
    bit done = 1'b0;
    bit reported = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        ic74x153_scan_reader #(.SETTLE(SET[k]), .AUTO_RESTART(AR[k])) u_dut (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_start (start[k]),
            .o_sel_hi(sel_hi[k]),
            .o_sel_lo(sel_lo[k]),
            .o_g1    (g1[k]),
            .o_g2    (g2[k]),
            .i_y1    (y1[k]),
            .i_y2    (y2[k]),
            .o_q1    (q1[k]),
            .o_q2    (q2[k]),
            .o_valid (valid[k]),
            .o_busy  (busy[k])
        );
        assign y1[k] = g1[k] ? 1'b0 : p1[k][{sel_hi[k], sel_lo[k]}];
        assign y2[k] = g2[k] ? 1'b0 : p2[k][{sel_hi[k], sel_lo[k]}];
    end

    // Reference model: a scan started at edge e0 samples address i at e0+S*(i+1)
    // and completes at e0+4*S; a start is only taken when no scan is running.
    int cyc = 0;
    int m_e0 [N];
    bit m_busy [N];
    bit m_valid [N];
    logic [3:0] acc1 [N];
    logic [3:0] acc2 [N];
    exp_t exp_q [N][$];

    always @(posedge clk or posedge rst) begin
        int d;
        exp_t e;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_busy[k]  = 1'b0;
                m_valid[k] = 1'b0;
                exp_q[k].delete();
            end
        end else begin
            cyc++;
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 1'b0;
                if (m_busy[k]) begin
                    d = cyc - m_e0[k];
                    if (d > 0 && (d % SET[k]) == 0) begin
                        acc1[k][d / SET[k] - 1] = p1[k][d / SET[k] - 1];
                        acc2[k][d / SET[k] - 1] = p2[k][d / SET[k] - 1];
                    end
                    if (d == 4 * SET[k]) begin
                        e.cyc = 32'(cyc);
                        e.q1  = acc1[k];
                        e.q2  = acc2[k];
                        exp_q[k].push_back(e);
                        m_valid[k] = 1'b1;
                        if (AR[k]) m_e0[k] = cyc;
                        else       m_busy[k] = 1'b0;
                    end
                end else if (start[k]) begin
                    m_busy[k] = 1'b1;
                    m_e0[k]   = cyc;
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
        end
    endtask

    // Monitor: checks strobe/select/busy every cycle and pops the scoreboard on valid.
    logic [3:0] last_q1 [N] = '{4'd0, 4'd0, 4'd0};
    logic [3:0] last_q2 [N] = '{4'd0, 4'd0, 4'd0};

    always @(negedge clk) begin
        exp_t e;
        logic [1:0] exp_addr;
        for (int k = 0; k < N; k++) begin
            exp_addr = m_busy[k] ? 2'((cyc - m_e0[k]) / SET[k]) : 2'd0;
            chk("busy",  k, 32'(busy[k]), 32'(m_busy[k]));
            chk("g1",    k, 32'(g1[k]),   32'(!m_busy[k]));
            chk("g2",    k, 32'(g2[k]),   32'(!m_busy[k]));
            chk("sel",   k, 32'({sel_hi[k], sel_lo[k]}), 32'(exp_addr));
            chk("valid", k, 32'(valid[k]), 32'(m_valid[k]));
            if (rst) begin
                last_q1[k] = 4'd0;
                last_q2[k] = 4'd0;
            end
            if (valid[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk("valid_unexpected", k, 32'(exp_q[k].size()), 32'd1);
                end else begin
                    e = exp_q[k].pop_front();
                    chk("valid_cycle", k, 32'(cyc), e.cyc);
                    last_q1[k] = e.q1;
                    last_q2[k] = e.q2;
                end
            end
            chk("q1", k, 32'(q1[k]), 32'(last_q1[k]));
            chk("q2", k, 32'(q2[k]), 32'(last_q2[k]));
        end
        if (done && !reported) begin
            for (int k = 0; k < N; k++) chk("queue_drained", k, 32'(exp_q[k].size()), 32'd0);
            reported = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [N-1:0] m);
        @(negedge clk) start = m;
        @(negedge clk) start = '0;
    endtask

    // Asserts reset between edges so outputs are seen clearing before the next rising edge.
    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            p1[k] = 4'b1010;
            p2[k] = 4'b0110;
        end
        #1 rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);

        pulse_start('1);
        idle(14);

        @(negedge clk) start = 3'b011;
        idle(6);
        start = '0;
        idle(14);

        pulse_start(3'b001);
        @(negedge clk) p1[0][0] = ~p1[0][0];
        idle(6);
        pulse_start(3'b001);
        idle(6);

        pulse_start(3'b011);
        do_reset();
        idle(2);
        pulse_start('1);
        idle(14);

        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) p1[k] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) p2[k] = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 199) == 0) do_reset();
        end
        start = '0;
        idle(16);
        done = 1'b1;
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
